sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. Generalises the team's 256x8 FIFO to arbitrary depth and width. Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. Used as the rate-matching buffer inside a single clock domain, wherever crossing clock domains is unnecessary.

Parameters:
DEPTH, 256, number of entries; any integer >= 2, power of two not required
DATA_WIDTH, 8, width of data_in/data_out in bits
ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden
AFULL_THRESH, DEPTH-4, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous clear of contents
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_THRESH
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_THRESH>0).
  - overflow=0, underflow=0.
  - rst overrides flush, wr_en and rd_en. Memory contents are not cleared.
- Accept rules use registered flags from the current cycle:
  - Write accepted iff wr_en && !full.
  - Read accepted iff rd_en && !empty.
  - When full, wr_en+rd_en: read accepted, write rejected, overflow set.
  - When empty, wr_en+rd_en: write accepted, read rejected, underflow set.
- Pointers advance by 1 on an accepted operation. They wrap explicitly from DEPTH-1 to 0, not by bit truncation.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- All flags are registered. They are derived from the next-state count, so they are valid in the same cycle as the updated count.
- Read latency (standard mode): data_out is loaded with mem[rd_ptr] on the edge that accepts the read and is valid the cycle after. data_out holds its value when no read is accepted.
- Write-to-read: a write accepted at edge N makes empty=0 after edge N. The earliest read is accepted at edge N+1.
- overflow/underflow: set on a rejected request, cleared only by rst. flush does not clear them.
- flush:
  - Sets wr_ptr=rd_ptr=0 and count=0; flags recompute to empty=1, almost_empty=1, full=0, almost_full=0.
  - Overrides wr_en/rd_en in the same cycle; no write stored, no read performed, no error flags set.
  - data_out held.
- Full/empty corners: at DEPTH=2, full and almost-full thresholds behave with the same rules; no special case.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr] whenever empty=0; rd_en acknowledges/pops the head.
  - After a pop, the next entry appears the following cycle.
  - data_out is don't-care while empty=1.
  - Accept rules, count and flags are unchanged.
- Undefined: standard registered-read mode, as described in Behaviour.

Test Plan:
(All scenarios use DEPTH=16, DATA_WIDTH=8, AFULL_THRESH=12, AEMPTY_THRESH=2, standard mode unless stated.)
- Reset: assert rst 2 cycles with wr_en=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, data_out=0x00.
- Fill/drain: write 0x01..0x10 back-to-back.
  - almost_empty falls after the 3rd write; almost_full rises after the 12th; full=1 after the 16th, count=16.
  - Then read 16 times -> data_out 0x01..0x10 in order, each valid 1 cycle after the read; empty=1 at end.
- Overflow/simultaneous:
  - At full, wr_en=1 rd_en=0 with 0xAA -> write dropped, overflow=1, count=16.
  - Then wr_en=1 rd_en=1 -> read accepted, write rejected, count=15, overflow still 1.
- Underflow: rd_en=1 while empty -> underflow=1, count=0, data_out unchanged; remains 1 until rst.
- Wrap and flush:
  - Write 10, read 10, write 10 (pointers wrap) -> reads return the correct order.
  - Then flush with wr_en=1 -> count=0, empty=1, nothing stored.
- FWFT (macro defined): write 0x5A to empty FIFO -> next cycle empty=0, data_out=0x5A without rd_en; pop -> empty=1 the next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, almost flags, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is a registered read.
module sync_fifo_param #(
    parameter int DEPTH         = 256,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = ADDR_WIDTH + 1;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic full_q, afull_q, empty_q, aempty_q, ovf_q, unf_q, ovf_d, unf_d;
    logic wr_acc, rd_acc;
    // Accept decisions use the registered flags; flush masks requests entirely.
    always_comb begin
        wr_acc   = wr_en && !full_q && !flush;
        rd_acc   = rd_en && !empty_q && !flush;
        wr_ptr_d = flush ? '0 : !wr_acc ? wr_ptr_q :
                   (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        rd_ptr_d = flush ? '0 : !rd_acc ? rd_ptr_q :
                   (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        count_d  = flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
        ovf_d    = ovf_q | (wr_en && full_q && !flush);
        unf_d    = unf_q | (rd_en && empty_q && !flush);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= (AFULL_THRESH <= 0);
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= count_d == CW'(DEPTH);
            afull_q  <= count_d >= CW'(AFULL_THRESH);
            empty_q  <= count_d == '0;
            aempty_q <= count_d <= CW'(AEMPTY_THRESH);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    always_ff @(posedge clk)
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk)
        if (rst) dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    assign data_out = dout_q;
`endif
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed test of sync_fifo_param at DEPTH=16, AFULL=12, AEMPTY=2.
module tb_sync_fifo_param;
    logic       clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0;
    logic [7:0] data_in = 0, data_out;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [4:0] count;
    int n_tests = 0, n_fail = 0;
    sync_fifo_param #(.DEPTH(16), .DATA_WIDTH(8), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .full(full), .almost_full(almost_full),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] d);
        wr_en = 1;
        data_in = d;
        tick();
        wr_en = 0;
    endtask
    // Pops one entry and checks it: head before the pop in FWFT, registered output after it otherwise.
    task automatic rd(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check(tag, data_out, exp);
        rd_en = 1;
        tick();
`else
        rd_en = 1;
        tick();
        check(tag, data_out, exp);
`endif
        rd_en = 0;
    endtask
    initial begin
        rst = 1;
        wr_en = 1;
        data_in = 8'h33;
        tick();
        tick();
        rst = 0;
        wr_en = 0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_dout", data_out, 0);
`endif
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            check("fill_count", count, i);
            check("fill_empty", empty, 0);
            check("fill_aempty", almost_empty, i <= 2);
            check("fill_afull", almost_full, i >= 12);
            check("fill_full", full, i == 16);
        end
        wr(8'hAA);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("sim_head", data_out, 8'h01);
`endif
        wr_en = 1;
        rd_en = 1;
        data_in = 8'hAA;
        tick();
        wr_en = 0;
        rd_en = 0;
`ifndef SYNC_FIFO_FWFT_EN
        check("sim_dout", data_out, 8'h01);
`endif
        check("sim_count", count, 15);
        check("sim_full", full, 0);
        check("sim_ovf", overflow, 1);
        for (int i = 2; i <= 16; i++) begin
            rd("drain_dout", 8'(i));
            check("drain_count", count, 16 - i);
        end
        check("drain_empty", empty, 1);
        check("drain_aempty", almost_empty, 1);
        rd_en = 1;
        tick();
        rd_en = 0;
        check("unf_flag", underflow, 1);
        check("unf_count", count, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_dout", data_out, 8'h10);
`endif
        tick();
        check("unf_sticky", underflow, 1);
        for (int i = 0; i < 10; i++) wr(8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) rd("wrap1_dout", 8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) wr(8'h30 + 8'(i));
        check("wrap_count", count, 10);
        for (int i = 0; i < 10; i++) rd("wrap2_dout", 8'h30 + 8'(i));
        check("wrap_empty", empty, 1);
        for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i));
        flush = 1;
        wr_en = 1;
        data_in = 8'h77;
        tick();
        flush = 0;
        wr_en = 0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_aempty", almost_empty, 1);
        check("flush_full", full, 0);
        check("flush_ovf_kept", overflow, 1);
        check("flush_unf_kept", underflow, 1);
        wr(8'h55);
        check("post_flush_count", count, 1);
        rd("post_flush_dout", 8'h55);
        check("post_flush_empty", empty, 1);
`ifdef SYNC_FIFO_FWFT_EN
        wr(8'h5A);
        check("fwft_empty", empty, 0);
        check("fwft_dout", data_out, 8'h5A);
        rd_en = 1;
        tick();
        rd_en = 0;
        check("fwft_pop_empty", empty, 1);
`endif
        rst = 1;
        tick();
        rst = 0;
        check("rst2_ovf", overflow, 0);
        check("rst2_unf", underflow, 0);
        check("rst2_count", count, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
